// File: rtl/mp64_entropy_fetch.sv
// Bus initiator that drains the mp64_trng responder into a first-word-fall-through FIFO.
// Define MP64_ENTROPY_DEDUP_EN to discard back-to-back identical RAND64 words (adds dup_cnt).
module mp64_entropy_fetch #(
    parameter int DEPTH   = 8,
    parameter int BACKOFF = 16,
    parameter int TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    output logic                     m_req,
    output logic [4:0]               m_addr,
    output logic [63:0]              m_wdata,
    output logic                     m_wen,
    input  logic [63:0]              m_rdata,
    input  logic                     m_ack,
    input  logic                     seed_valid,
    input  logic [63:0]              seed_data,
    output logic                     seed_ready,
    input  logic                     pop,
    output logic [63:0]              dout,
    output logic                     dvalid,
    output logic [$clog2(DEPTH):0]   level,
`ifdef MP64_ENTROPY_DEDUP_EN
    output logic [7:0]               dup_cnt,
`endif
    output logic                     err
);

    localparam int PW   = $clog2(DEPTH);
    localparam int LW   = PW + 1;
    localparam int TMAX = (BACKOFF > TIMEOUT) ? BACKOFF : TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_RAND   = 5'h08;
    localparam logic [4:0] ADDR_SEED   = 5'h18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_BACKOFF,
        S_FETCH,
        S_SEED
    } state_t;

    state_t          state_q, state_d;
    logic            m_req_q, m_req_d;
    logic [4:0]      m_addr_q, m_addr_d;
    logic [63:0]     m_wdata_q, m_wdata_d;
    logic            m_wen_q, m_wen_d;
    logic [63:0]     seed_q, seed_d;
    logic            seed_ready_q, seed_ready_d;
    logic            seeded_q, seeded_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [63:0]     fifo_mem [DEPTH];
    logic            push;
    logic            pop_ok;
    logic            ack_ok;
    logic            timed_out;
`ifdef MP64_ENTROPY_DEDUP_EN
    logic [63:0]     last_q, last_d;
    logic            last_valid_q, last_valid_d;
    logic [7:0]      dup_cnt_q, dup_cnt_d;
`endif

    assign ack_ok    = m_req_q & m_ack;
    assign timed_out = m_req_q & ~m_ack & (timer_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_wen_d   = m_wen_q;
        seed_d    = seed_q;
        seeded_d  = seeded_q;
        err_d     = err_q;
        timer_d   = timer_q;
        push      = 1'b0;
`ifdef MP64_ENTROPY_DEDUP_EN
        last_d       = last_q;
        last_valid_d = last_valid_q;
        dup_cnt_d    = dup_cnt_q;
`endif

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (seed_valid && seed_ready_q) begin
                    seed_d  = seed_data;
                    state_d = S_SEED;
                end else if (en && (level_q < LW'(DEPTH))) begin
                    state_d = seeded_q ? S_FETCH : S_POLL;
                end
            end
            S_BACKOFF: begin
                if (timer_q == TW'(BACKOFF - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                // Bus states: issue one cycle after entry, then wait for ack or timeout.
                if (!m_req_q) begin
                    m_req_d = 1'b1;
                    timer_d = '0;
                    m_wen_d = (state_q == S_SEED);
                    m_wdata_d = (state_q == S_SEED) ? seed_q : 64'd0;
                    m_addr_d = (state_q == S_POLL)  ? ADDR_STATUS :
                               (state_q == S_FETCH) ? ADDR_RAND : ADDR_SEED;
                end else if (ack_ok || timed_out) begin
                    m_req_d   = 1'b0;
                    m_addr_d  = '0;
                    m_wdata_d = '0;
                    m_wen_d   = 1'b0;
                    state_d   = S_IDLE;
                    if (timed_out) begin
                        err_d    = 1'b1;
                        seeded_d = 1'b0;
                    end else if (state_q == S_POLL) begin
                        if (m_rdata[0]) begin
                            seeded_d = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            timer_d = '0;
                            state_d = S_BACKOFF;
                        end
                    end else if (state_q == S_SEED) begin
                        seeded_d = 1'b0;
                    end else begin
`ifdef MP64_ENTROPY_DEDUP_EN
                        last_d       = m_rdata;
                        last_valid_d = 1'b1;
                        if (last_valid_q && (m_rdata == last_q)) begin
                            err_d    = 1'b1;
                            seeded_d = 1'b0;
                            if (dup_cnt_q != 8'hFF) dup_cnt_d = dup_cnt_q + 8'd1;
                        end else begin
                            push = 1'b1;
                        end
`else
                        push = 1'b1;
`endif
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase

        seed_ready_d = (state_d == S_IDLE);
    end

    always_comb begin
        pop_ok   = pop && (level_q != '0);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            m_req_q      <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            m_wen_q      <= 1'b0;
            seed_q       <= '0;
            seed_ready_q <= 1'b0;
            seeded_q     <= 1'b0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
        end else begin
            state_q      <= state_d;
            m_req_q      <= m_req_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wen_q      <= m_wen_d;
            seed_q       <= seed_d;
            seed_ready_q <= seed_ready_d;
            seeded_q     <= seeded_d;
            err_q        <= err_d;
            timer_q      <= timer_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is visible.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= m_rdata;
    end

`ifdef MP64_ENTROPY_DEDUP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q       <= '0;
            last_valid_q <= 1'b0;
            dup_cnt_q    <= '0;
        end else begin
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
            dup_cnt_q    <= dup_cnt_d;
        end
    end

    assign dup_cnt = dup_cnt_q;
`endif

    assign m_req      = m_req_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;
    assign m_wen      = m_wen_q;
    assign seed_ready = seed_ready_q;
    assign err        = err_q;
    assign level      = level_q;
    assign dvalid     = (level_q != '0);
    assign dout       = dvalid ? fifo_mem[rd_ptr_q] : 64'd0;

endmodule

// File: tb/tb_mp64_entropy_fetch.sv
// Directed bench for mp64_entropy_fetch with a behavioural TRNG responder.
// Build with MP64_ENTROPY_DEDUP_EN defined to exercise the duplicate-discard variant.
module tb_mp64_entropy_fetch;

    localparam int DEPTH   = 8;
    localparam int BACKOFF = 16;
    localparam int TIMEOUT = 32;
    localparam logic [63:0] DUP_WORD  = 64'h5A5A_A5A5_1234_4321;
    localparam logic [63:0] SEED_WORD = 64'hDEADBEEFCAFEBABE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        m_req;
    logic [4:0]  m_addr;
    logic [63:0] m_wdata;
    logic        m_wen;
    logic [63:0] m_rdata;
    logic        m_ack;
    logic        seed_valid;
    logic [63:0] seed_data;
    logic        seed_ready;
    logic        pop;
    logic [63:0] dout;
    logic        dvalid;
    logic [3:0]  level;
    logic        err;
`ifdef MP64_ENTROPY_DEDUP_EN
    logic [7:0]  dup_cnt;
`endif

    mp64_entropy_fetch #(.DEPTH(DEPTH), .BACKOFF(BACKOFF), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata), .m_wen(m_wen),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .seed_valid(seed_valid), .seed_data(seed_data), .seed_ready(seed_ready),
        .pop(pop), .dout(dout), .dvalid(dvalid), .level(level),
`ifdef MP64_ENTROPY_DEDUP_EN
        .dup_cnt(dup_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Responder controls, written only by the main sequence
    int ack_delay   = 0;
    bit no_ack      = 1'b0;
    bit dup_mode    = 1'b0;
    int status_zero = 0;
    int poll_base   = 0;
    int fetch_base  = 0;

    // Responder observations, written only by the responder
    int          poll_cnt = 0;
    int          fetch_cnt = 0;
    int          write_cnt = 0;
    int          start_cnt = 0;
    logic [4:0]  last_start_addr = '0;
    logic [4:0]  ack_addr = '0;
    logic        ack_wen = 1'b0;
    logic [63:0] ack_wdata = '0;
    int          cur_len = 0;
    int          last_len = 0;
    int          cyc = 0;
    int          prev_poll_cyc = -1000;
    int          min_poll_gap = 1000;
    bit          acked = 1'b0;
    int          wait_cnt = 0;

    function automatic logic [63:0] rand_word(input int k);
        return 64'h0123456789ABCDEF + 64'(k) * 64'h0000_0100_0001_0001;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic rst, input logic enable);
        rst_n = rst;
        en    = enable;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0);
        pop = 1'b0; seed_valid = 1'b0; seed_data = '0;
        no_ack = 1'b0; dup_mode = 1'b0; ack_delay = 0; status_zero = 0;
        repeat (3) tick();
        poll_base  = poll_cnt;
        fetch_base = fetch_cnt;
        rst_n = 1'b1;
        tick();
    endtask

    // Behavioural TRNG: acks after ack_delay cycles, STATUS reads 0 for the first status_zero polls
    initial begin
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            m_ack = 1'b0;
            m_rdata = '0;
            if (!rst_n) begin
                acked = 1'b0; wait_cnt = 0; cur_len = 0;
            end else if (m_req) begin
                if (cur_len == 0) begin
                    start_cnt++;
                    last_start_addr = m_addr;
                    if (m_addr == 5'h10) begin
                        if (cyc - prev_poll_cyc < min_poll_gap) min_poll_gap = cyc - prev_poll_cyc;
                        prev_poll_cyc = cyc;
                    end
                end
                cur_len++;
                if (!acked && !no_ack) begin
                    if (wait_cnt >= ack_delay) begin
                        m_ack = 1'b1;
                        acked = 1'b1;
                        ack_addr = m_addr; ack_wen = m_wen; ack_wdata = m_wdata;
                        if (m_addr == 5'h10) begin
                            m_rdata = ((poll_cnt - poll_base) < status_zero) ? 64'd0 : 64'd1;
                            poll_cnt++;
                        end else if (m_addr == 5'h08) begin
                            m_rdata = dup_mode ? DUP_WORD : rand_word(fetch_cnt - fetch_base);
                            fetch_cnt++;
                        end else begin
                            write_cnt++;
                        end
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                if (cur_len > 0) last_len = cur_len;
                cur_len = 0; acked = 1'b0; wait_cnt = 0;
            end
        end
    end

    initial begin
        int i, sc, wc, pops, level_bad;
        bit reached;

        // Reset values
        applyStimulus(1'b0, 1'b0);
        pop = 1'b0; seed_valid = 1'b0; seed_data = '0;
        repeat (2) tick();
        checkOutput("rst_m_req", m_req, 1'b0);
        checkOutput("rst_m_addr", m_addr, 5'h00);
        checkOutput("rst_level", level, 4'd0);
        checkOutput("rst_dvalid", dvalid, 1'b0);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_seed_ready", seed_ready, 1'b0);

        // Test 1: three unseeded polls, then first RAND64 word
        doReset();
        status_zero = 3;
        en = 1'b1;
        for (i = 0; i < 400 && !dvalid; i++) tick();
        checkOutput("t1_dvalid_wait", dvalid, 1'b1);
        checkOutput("t1_polls", poll_cnt - poll_base, 4);
        checkOutput("t1_fetches", fetch_cnt - fetch_base, 1);
        checkOutput("t1_dout", dout, 64'h0123456789ABCDEF);
        checkOutput("t1_poll_gap_ok", min_poll_gap >= BACKOFF, 1'b1);

        // Test 2: fill to DEPTH without pops, then one pop refetches exactly once
        for (i = 0; i < 500 && level != 4'd8; i++) tick();
        sc = start_cnt;
        repeat (60) tick();
        checkOutput("t2_fetches", fetch_cnt - fetch_base, DEPTH);
        checkOutput("t2_level_full", level, 4'd8);
        checkOutput("t2_no_new_req", start_cnt, sc);
        checkOutput("t2_m_req_idle", m_req, 1'b0);
        checkOutput("t2_head", dout, rand_word(0));
        pop = 1'b1;
        tick();
        pop = 1'b0;
        checkOutput("t2_next_head", dout, rand_word(1));
        repeat (60) tick();
        checkOutput("t2_refetch", fetch_cnt - fetch_base, DEPTH + 1);
        checkOutput("t2_level_refill", level, 4'd8);

        // Test 3: seed write, then the next transaction is a STATUS poll
        doReset();
        en = 1'b1;
        for (i = 0; i < 200 && (fetch_cnt - fetch_base) < 1; i++) tick();
        en = 1'b0;
        repeat (10) tick();
        for (i = 0; i < 50 && !seed_ready; i++) tick();
        checkOutput("t3_ready_wait", seed_ready, 1'b1);
        sc = start_cnt;
        wc = write_cnt;
        seed_valid = 1'b1;
        seed_data  = SEED_WORD;
        @(posedge clk);
        #1;
        seed_valid = 1'b0;
        for (i = 0; i < 100 && write_cnt == wc; i++) tick();
        repeat (5) tick();
        checkOutput("t3_write_cnt", write_cnt - wc, 1);
        checkOutput("t3_single_txn", start_cnt - sc, 1);
        checkOutput("t3_addr", ack_addr, 5'h18);
        checkOutput("t3_wen", ack_wen, 1'b1);
        checkOutput("t3_wdata", ack_wdata, SEED_WORD);
        sc = start_cnt;
        en = 1'b1;
        for (i = 0; i < 100 && start_cnt == sc; i++) tick();
        checkOutput("t3_next_is_poll", last_start_addr, 5'h10);

        // Test 4: responder stops acking, request times out
        doReset();
        en = 1'b1;
        for (i = 0; i < 200 && (fetch_cnt - fetch_base) < 1; i++) tick();
        no_ack = 1'b1;
        for (i = 0; i < 200 && !err; i++) tick();
        checkOutput("t4_err_set", err, 1'b1);
        checkOutput("t4_req_len", last_len, TIMEOUT);
        checkOutput("t4_req_dropped", m_req, 1'b0);
        sc = start_cnt;
        no_ack = 1'b0;
        for (i = 0; i < 100 && start_cnt == sc; i++) tick();
        checkOutput("t4_next_is_poll", last_start_addr, 5'h10);
        repeat (40) tick();
        checkOutput("t4_err_sticky", err, 1'b1);

        // Test 5: pop coincides with push at level 4, order preserved across wrap
        doReset();
        ack_delay = 2;
        en = 1'b1;
        pops = 0;
        level_bad = 0;
        reached = 1'b0;
        for (i = 0; i < 3000 && pops < 16; i++) begin
            tick();
            pop = 1'b0;
            if (reached && level != 4'd4) level_bad++;
            if (level == 4'd4) reached = 1'b1;
            if (m_ack && m_addr == 5'h08 && level == 4'd4) begin
                checkOutput("t5_order", dout, rand_word(pops));
                pop = 1'b1;
                pops++;
            end
        end
        tick();
        pop = 1'b0;
        checkOutput("t5_pops", pops, 16);
        checkOutput("t5_level_held", level_bad, 0);
        checkOutput("t5_level_end", level, 4'd4);

        // Test 6: responder repeats the same RAND64 word
        doReset();
        dup_mode = 1'b1;
        en = 1'b1;
        for (i = 0; i < 200 && (fetch_cnt - fetch_base) < 2; i++) tick();
        en = 1'b0;
        repeat (10) tick();
        checkOutput("t6_fetches", fetch_cnt - fetch_base, 2);
        checkOutput("t6_head", dout, DUP_WORD);
`ifdef MP64_ENTROPY_DEDUP_EN
        checkOutput("t6_level", level, 4'd1);
        checkOutput("t6_dup_cnt", dup_cnt, 8'd1);
        checkOutput("t6_err", err, 1'b1);
`else
        checkOutput("t6_level", level, 4'd2);
        checkOutput("t6_err", err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
